// File: rtl/baccarat_pkg.sv
// Shared types and constants for the baccarat hand controller.
package baccarat_pkg;

  localparam logic [3:0] NATURAL_MIN = 4'd8;
  localparam logic [3:0] DRAW_MAX    = 4'd5;
  localparam logic [3:0] FACE_MIN    = 4'd10;

  typedef enum logic [3:0] {
    S_P1,
    S_D1,
    S_P2,
    S_D2,
    S_CHK,
    S_P3,
    S_BNK,
    S_D3,
    S_DONE
  } state_t;

  // Banker third-card rule once the player has drawn; v is the player's third-card value.
  function automatic logic banker_draws(input logic [3:0] dscore, input logic [3:0] v);
    logic draw;
    draw = 1'b0;
    case (dscore)
      4'd0, 4'd1, 4'd2: draw = 1'b1;
      4'd3:             draw = (v != 4'd8);
      4'd4:             draw = (v >= 4'd2) && (v <= 4'd7);
      4'd5:             draw = (v >= 4'd4) && (v <= 4'd7);
      4'd6:             draw = (v >= 4'd6) && (v <= 4'd7);
      default:          draw = 1'b0;
    endcase
    return draw;
  endfunction

endpackage

// File: rtl/card_value.sv
// Maps a 4-bit card code to its baccarat point value (faces and tens count zero).
module card_value
  import baccarat_pkg::*;
(
  input  logic [3:0] code,
  output logic [3:0] value
);

  // Codes 10..13 are worth nothing; everything else is worth its code.
  always_comb begin
    value = (code >= FACE_MIN) ? 4'd0 : code;
  end

endmodule

// File: rtl/baccarat_fsm.sv
// Moore controller sequencing the deal of one baccarat hand and deciding the result.
module baccarat_fsm
  import baccarat_pkg::*;
(
  input  logic       slow_clock,
  input  logic       resetb,
  input  logic [3:0] pcard3_out,
  input  logic [3:0] pscore_out,
  input  logic [3:0] dscore_out,
  output logic       load_pcard1,
  output logic       load_pcard2,
  output logic       load_pcard3,
  output logic       load_dcard1,
  output logic       load_dcard2,
  output logic       load_dcard3,
  output logic       player_win_light,
  output logic       dealer_win_light,
  output logic       game_over
);

  state_t     state_q, state_d;
  logic [3:0] pcard3_value;

  card_value u_pcard3_value (
    .code  (pcard3_out),
    .value (pcard3_value)
  );

  // State register; synchronous reset wins over every transition.
  always_ff @(posedge slow_clock) begin
    if (!resetb) begin
      state_q <= S_P1;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: fixed four-card deal, then the third-card rules.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_P1:  state_d = S_D1;
      S_D1:  state_d = S_P2;
      S_P2:  state_d = S_D2;
      S_D2:  state_d = S_CHK;
      S_CHK: begin
        if ((pscore_out >= NATURAL_MIN) || (dscore_out >= NATURAL_MIN)) begin
          state_d = S_DONE;
        end else if (pscore_out <= DRAW_MAX) begin
          state_d = S_P3;
        end else if (dscore_out <= DRAW_MAX) begin
          state_d = S_D3;
        end else begin
          state_d = S_DONE;
        end
      end
      S_P3:  state_d = S_BNK;
      S_BNK: state_d = banker_draws(dscore_out, pcard3_value) ? S_D3 : S_DONE;
      S_D3:  state_d = S_DONE;
      S_DONE: state_d = S_DONE;
      default: state_d = S_P1;
    endcase
  end

  // Outputs decoded from the current state (and scores for the lights).
  always_comb begin
    load_pcard1      = (state_q == S_P1);
    load_dcard1      = (state_q == S_D1);
    load_pcard2      = (state_q == S_P2);
    load_dcard2      = (state_q == S_D2);
    load_pcard3      = (state_q == S_P3);
    load_dcard3      = (state_q == S_D3);
    game_over        = (state_q == S_DONE);
    // Equal scores light both lamps, signalling a tie.
    player_win_light = game_over && (pscore_out >= dscore_out);
    dealer_win_light = game_over && (dscore_out >= pscore_out);
  end

endmodule

// File: tb/tb_baccarat_fsm.sv
// Directed bench: models card registers and scorer around the controller.
module tb_baccarat_fsm;

  logic       slow_clock;
  logic       resetb;
  logic [3:0] pcard3_out, pscore_out, dscore_out;
  logic       load_pcard1, load_pcard2, load_pcard3;
  logic       load_dcard1, load_dcard2, load_dcard3;
  logic       player_win_light, dealer_win_light, game_over;

  int checks = 0;
  int errors = 0;
  logic mon_en = 1'b0;

  logic [3:0] scr_p [3];
  logic [3:0] scr_d [3];
  logic [3:0] pc1, pc2, pc3, dc1, dc2, dc3;
  int pc3_cnt, dc3_cnt;

  baccarat_fsm dut (
    .slow_clock       (slow_clock),
    .resetb           (resetb),
    .pcard3_out       (pcard3_out),
    .pscore_out       (pscore_out),
    .dscore_out       (dscore_out),
    .load_pcard1      (load_pcard1),
    .load_pcard2      (load_pcard2),
    .load_pcard3      (load_pcard3),
    .load_dcard1      (load_dcard1),
    .load_dcard2      (load_dcard2),
    .load_dcard3      (load_dcard3),
    .player_win_light (player_win_light),
    .dealer_win_light (dealer_win_light),
    .game_over        (game_over)
  );

  initial begin
    slow_clock = 1'b0;
    forever #5 slow_clock = ~slow_clock;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation still running at %0t, required finish earlier", $time);
    $fatal(1);
  end

  function automatic int val(input logic [3:0] c);
    return (c >= 4'd10) ? 0 : int'(c);
  endfunction

  // Card registers; reset clears them and overrides any concurrent load.
  always @(posedge slow_clock) begin
    if (!resetb) begin
      pc1 <= 4'd0; pc2 <= 4'd0; pc3 <= 4'd0;
      dc1 <= 4'd0; dc2 <= 4'd0; dc3 <= 4'd0;
      pc3_cnt <= 0; dc3_cnt <= 0;
    end else begin
      if (load_pcard1) pc1 <= scr_p[0];
      if (load_pcard2) pc2 <= scr_p[1];
      if (load_pcard3) begin pc3 <= scr_p[2]; pc3_cnt <= pc3_cnt + 1; end
      if (load_dcard1) dc1 <= scr_d[0];
      if (load_dcard2) dc2 <= scr_d[1];
      if (load_dcard3) begin dc3 <= scr_d[2]; dc3_cnt <= dc3_cnt + 1; end
    end
  end

  always_comb begin
    pcard3_out = pc3;
    pscore_out = 4'((val(pc1) + val(pc2) + val(pc3)) % 10);
    dscore_out = 4'((val(dc1) + val(dc2) + val(dc3)) % 10);
  end

  // At most one load strobe per cycle.
  always @(negedge slow_clock) begin
    if (mon_en) begin
      checks++;
      if ($countones({load_pcard1, load_pcard2, load_pcard3,
                      load_dcard1, load_dcard2, load_dcard3}) > 1) begin
        errors++;
        $display("FAIL one_hot at %0t: strobes=%b, required at most one high", $time,
                 {load_pcard1, load_pcard2, load_pcard3, load_dcard1, load_dcard2, load_dcard3});
      end
    end
  end

  // Reset, release, then count edges until game_over (99 if the budget expires).
  task automatic run_hand(input logic [3:0] p1, p2, p3, d1, d2, d3, output int edges);
    scr_p[0] = p1; scr_p[1] = p2; scr_p[2] = p3;
    scr_d[0] = d1; scr_d[1] = d2; scr_d[2] = d3;
    @(negedge slow_clock);
    resetb = 1'b0;
    @(posedge slow_clock);
    @(negedge slow_clock);
    resetb = 1'b1;
    edges = 0;
    while (!game_over && edges < 20) begin
      @(posedge slow_clock);
      edges++;
      @(negedge slow_clock);
    end
    if (!game_over) edges = 99;
  endtask

  task automatic test_reset;
    scr_p[0] = 4'd1; scr_p[1] = 4'd1; scr_p[2] = 4'd1;
    scr_d[0] = 4'd1; scr_d[1] = 4'd1; scr_d[2] = 4'd1;
    resetb = 1'b0;
    @(posedge slow_clock);
    @(negedge slow_clock);
    mon_en = 1'b1;
    checks++;
    if (game_over !== 1'b0) begin errors++; $display("FAIL reset_game_over: got %b, want 0", game_over); end
    checks++;
    if ({player_win_light, dealer_win_light} !== 2'b00) begin
      errors++; $display("FAIL reset_lights: got %b, want 00", {player_win_light, dealer_win_light});
    end
    checks++;
    if ({load_pcard1, load_dcard1, load_pcard2, load_dcard2, load_pcard3, load_dcard3} !== 6'b100000) begin
      errors++;
      $display("FAIL reset_strobes: got %b, want 100000",
               {load_pcard1, load_dcard1, load_pcard2, load_dcard2, load_pcard3, load_dcard3});
    end
  endtask

  task automatic test_natural;
    int e;
    run_hand(4'd8, 4'd13, 4'd0, 4'd3, 4'd2, 4'd0, e);
    checks++; if (e !== 5) begin errors++; $display("FAIL natural_edges: got %0d, want 5", e); end
    checks++;
    if ({player_win_light, dealer_win_light} !== 2'b10) begin
      errors++; $display("FAIL natural_lights: got %b, want 10", {player_win_light, dealer_win_light});
    end
    checks++;
    if (pc3_cnt !== 0 || dc3_cnt !== 0) begin
      errors++; $display("FAIL natural_third: got p3=%0d d3=%0d, want 0 0", pc3_cnt, dc3_cnt);
    end
  endtask

  task automatic test_player_draws;
    int e;
    run_hand(4'd2, 4'd3, 4'd8, 4'd1, 4'd2, 4'd0, e);
    checks++; if (e !== 7) begin errors++; $display("FAIL pdraw_edges: got %0d, want 7", e); end
    checks++;
    if ({player_win_light, dealer_win_light} !== 2'b11) begin
      errors++; $display("FAIL pdraw_lights: got %b, want 11", {player_win_light, dealer_win_light});
    end
    checks++;
    if (pc3_cnt !== 1 || dc3_cnt !== 0) begin
      errors++; $display("FAIL pdraw_third: got p3=%0d d3=%0d, want 1 0", pc3_cnt, dc3_cnt);
    end
  endtask

  task automatic test_banker_draws;
    int e;
    run_hand(4'd3, 4'd4, 4'd0, 4'd2, 4'd2, 4'd5, e);
    checks++; if (e !== 6) begin errors++; $display("FAIL bdraw_edges: got %0d, want 6", e); end
    checks++;
    if ({player_win_light, dealer_win_light} !== 2'b01) begin
      errors++; $display("FAIL bdraw_lights: got %b, want 01", {player_win_light, dealer_win_light});
    end
    checks++;
    if (pc3_cnt !== 0 || dc3_cnt !== 1) begin
      errors++; $display("FAIL bdraw_third: got p3=%0d d3=%0d, want 0 1", pc3_cnt, dc3_cnt);
    end
  endtask

  task automatic test_banker_six;
    int e;
    // v=6 against banker 6: banker draws, final P=1 D=8.
    run_hand(4'd1, 4'd4, 4'd6, 4'd3, 4'd3, 4'd2, e);
    checks++; if (e !== 8) begin errors++; $display("FAIL b6_draw_edges: got %0d, want 8", e); end
    checks++;
    if (pc3_cnt !== 1 || dc3_cnt !== 1) begin
      errors++; $display("FAIL b6_draw_third: got p3=%0d d3=%0d, want 1 1", pc3_cnt, dc3_cnt);
    end
    checks++;
    if ({player_win_light, dealer_win_light} !== 2'b01) begin
      errors++; $display("FAIL b6_draw_lights: got %b, want 01", {player_win_light, dealer_win_light});
    end
    // King is worth zero: banker 6 stands, final P=5 D=6.
    run_hand(4'd1, 4'd4, 4'd13, 4'd3, 4'd3, 4'd2, e);
    checks++; if (e !== 7) begin errors++; $display("FAIL b6_stand_edges: got %0d, want 7", e); end
    checks++;
    if (pc3_cnt !== 1 || dc3_cnt !== 0) begin
      errors++; $display("FAIL b6_stand_third: got p3=%0d d3=%0d, want 1 0", pc3_cnt, dc3_cnt);
    end
    checks++;
    if ({player_win_light, dealer_win_light} !== 2'b01) begin
      errors++; $display("FAIL b6_stand_lights: got %b, want 01", {player_win_light, dealer_win_light});
    end
  endtask

  task automatic test_both_stand;
    int e;
    // P=6, D=6: nobody draws, tie.
    run_hand(4'd3, 4'd3, 4'd0, 4'd4, 4'd2, 4'd0, e);
    checks++; if (e !== 5) begin errors++; $display("FAIL stand_edges: got %0d, want 5", e); end
    checks++;
    if ({player_win_light, dealer_win_light} !== 2'b11) begin
      errors++; $display("FAIL stand_lights: got %b, want 11", {player_win_light, dealer_win_light});
    end
  endtask

  task automatic test_done_absorbing;
    for (int i = 0; i < 3; i++) begin
      @(posedge slow_clock);
      @(negedge slow_clock);
      checks++;
      if (game_over !== 1'b1 ||
          {load_pcard1, load_dcard1, load_pcard2, load_dcard2, load_pcard3, load_dcard3} !== 6'b0) begin
        errors++;
        $display("FAIL done_hold: got game_over=%b strobes=%b, want 1 000000", game_over,
                 {load_pcard1, load_dcard1, load_pcard2, load_dcard2, load_pcard3, load_dcard3});
      end
    end
  endtask

  task automatic test_reset_mid_hand;
    int e;
    scr_p[0] = 4'd2; scr_p[1] = 4'd3; scr_p[2] = 4'd8;
    scr_d[0] = 4'd1; scr_d[1] = 4'd2; scr_d[2] = 4'd0;
    @(negedge slow_clock);
    resetb = 1'b0;
    @(posedge slow_clock);
    @(negedge slow_clock);
    resetb = 1'b1;
    repeat (5) begin
      @(posedge slow_clock);
      @(negedge slow_clock);
    end
    checks++;
    if (load_pcard3 !== 1'b1) begin errors++; $display("FAIL mid_in_p3: got %b, want 1", load_pcard3); end
    resetb = 1'b0;
    @(posedge slow_clock);
    @(negedge slow_clock);
    checks++;
    if ({load_pcard1, load_pcard3, game_over, player_win_light, dealer_win_light} !== 5'b10000) begin
      errors++;
      $display("FAIL mid_reset: got p1,p3,go,pw,dw=%b, want 10000",
               {load_pcard1, load_pcard3, game_over, player_win_light, dealer_win_light});
    end
    resetb = 1'b1;
    e = 0;
    while (!game_over && e < 20) begin
      @(posedge slow_clock);
      e++;
      @(negedge slow_clock);
    end
    if (!game_over) e = 99;
    checks++; if (e !== 7) begin errors++; $display("FAIL mid_replay_edges: got %0d, want 7", e); end
    checks++;
    if ({player_win_light, dealer_win_light} !== 2'b11 || pc3_cnt !== 1 || dc3_cnt !== 0) begin
      errors++;
      $display("FAIL mid_replay_result: got lights=%b p3=%0d d3=%0d, want 11 1 0",
               {player_win_light, dealer_win_light}, pc3_cnt, dc3_cnt);
    end
  endtask

  initial begin
    test_reset;
    test_natural;
    test_player_draws;
    test_banker_draws;
    test_banker_six;
    test_done_absorbing;
    test_both_stand;
    test_reset_mid_hand;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/baccarat_fsm.md
BACCARAT_FSM -- requirements
Module: baccarat_fsm

Interface
REQ-001 Parameters: none.
REQ-002 slow_clock  input  1  sole clock; all state changes on rising edge.
REQ-003 resetb  input  1  reset, synchronous, active-low.
REQ-004 pcard3_out  input  4  player third-card code (0 = none, 1..13 = A..K), registered downstream.
REQ-005 pscore_out  input  4  player hand score 0..9, registered downstream.
REQ-006 dscore_out  input  4  dealer hand score 0..9, registered downstream.
REQ-007 load_pcard1, load_pcard2, load_pcard3  output  1 each  player card-register load strobes.
REQ-008 load_dcard1, load_dcard2, load_dcard3  output  1 each  dealer card-register load strobes.
REQ-009 player_win_light, dealer_win_light  output  1 each  result lights; both high = tie.
REQ-010 game_over  output  1  high while the hand is finished.

Function
REQ-011 Moore FSM, states: S_P1, S_D1, S_P2, S_D2, S_CHK, S_P3, S_BNK, S_D3, S_DONE.
REQ-012 Load strobes decoded from state only: S_P1→load_pcard1, S_D1→load_dcard1, S_P2→load_pcard2, S_D2→load_dcard2, S_P3→load_pcard3, S_D3→load_dcard3; all others zero.
REQ-013 At most one load strobe high in any cycle.
REQ-014 Fixed sequence: S_P1→S_D1→S_P2→S_D2→S_CHK, one state per edge; the card is captured on the edge leaving the loading state.
REQ-015 In S_CHK, scores reflect four dealt cards; next state: pscore≥8 or dscore≥8 → S_DONE; else pscore≤5 → S_P3; else dscore≤5 → S_D3; else → S_DONE.
REQ-016 S_P3 → S_BNK unconditionally.
REQ-017 In S_BNK, v = card value of pcard3_out (codes 10..13 → 0, else code).
REQ-018 S_BNK draw rule (→S_D3 if true, else S_DONE): dscore 0..2 always; 3 if v≠8; 4 if v in 2..7; 5 if v in 4..7; 6 if v in 6..7; 7..9 never.
REQ-019 S_D3 → S_DONE unconditionally.
REQ-020 S_DONE is absorbing until reset; no load strobes.
REQ-021 Lights decoded from S_DONE and scores: player_win_light = pscore>dscore, dealer_win_light = dscore>pscore, both high when equal; both low outside S_DONE.
REQ-022 game_over = 1 exactly in S_DONE.
REQ-023 Worst-case hand: 8 edges from S_P1 to S_DONE; best case (natural): 5 edges.
REQ-024 Scores outside 0..9 are never produced upstream; the FSM treats any value ≥8 as natural in S_CHK.

Reset
REQ-025 resetb=0 at a rising edge forces S_P1 regardless of current state, including mid-hand.
REQ-026 Reset dominates all transitions; after the reset edge: state S_P1, lights 0, game_over 0, load_pcard1 1 (the datapath's concurrent reset dominates that strobe).
REQ-027 First edge with resetb=1 after reset loads player card 1.

Structure
REQ-028 Shared package baccarat_pkg holds the state enum, NATURAL_MIN=8, DRAW_MAX=5, FACE_MIN=10.
REQ-029 One sub-module card_value: combinational 4-bit card code → 4-bit baccarat value, reused by the datapath scorer.
REQ-030 Next-state logic in one combinational block; state register in one sequential block; outputs decoded from state.

Verification
REQ-031 Bench models the card registers and scorer, with scripted card codes and a one-hot checker on the six strobes every cycle.
REQ-032 Natural: P=8,13 (8); D=3,2 (5) → S_CHK→S_DONE; no third-card strobes; player_win_light=1, dealer_win_light=0 after 5 edges.
REQ-033 Player draws, banker stands: P=2,3 (5); D=1,2 (3); pcard3=8 → load_pcard3 pulses once, no load_dcard3; final P=3 vs D=3 → both lights high.
REQ-034 Player stands, banker draws: P=3,4 (7); D=2,2 (4) → S_CHK→S_D3; load_dcard3 pulses; no load_pcard3; lights per final scores.
REQ-035 Banker 6 with v=6: P=1,4, pcard3=6; D=3,3 → S_BNK→S_D3; with pcard3=13 instead → S_BNK→S_DONE.
REQ-036 Reset mid-hand: assert resetb=0 while in S_P3 → next edge S_P1, all lights 0, game_over 0; the hand then replays correctly.
